free_list: RTL and testbench
============================

Name: free_list

Overview:
- Circular FIFO of free physical register indices for R10K-style renaming.
- Each cycle it supplies up to N new physical registers to the map table, one per dispatching instruction with a nonzero destination.
- It takes back the old mappings (T_old) of retiring instructions.
- It keeps a retirement-time copy of the head pointer, so a branch-mispredict recovery (map table restored from the architectural map table) also restores the free list in one cycle.

Parameters:
- N, `N: superscalar width; number of alloc and free lanes.
- PHYS_SZ, `PHYS_REG_SZ: number of physical registers.
- ARCH_SZ, `ARCH_REG_SZ: number of architectural registers.
- DEPTH, PHYS_SZ-ARCH_SZ: FIFO capacity. Must be a power of 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- alloc_req  in  [N-1:0]  lane i requests one free register. Set only for a valid instruction with dest != 0.
- free_reg  out  PHYS_REG_IDX[N-1:0]  register granted to each requesting lane. Combinational.
- alloc_stall  out  1  popcount(alloc_req) > free_count. Combinational.
- free_count  out  $clog2(DEPTH+1)  registered number of free entries.
- num_avail  out  $clog2(N+1)  min(free_count, N), used by dispatch.
- retire_valid  in  [N-1:0]  lane i retires an instruction with dest != 0.
- retire_t_old  in  PHYS_REG_IDX[N-1:0]  T_old of that instruction, returned to the list.
- restore_en  in  1  mispredict recovery; same cycle as the map table's in_mt_en.
- overflow_err  out  1  registered sticky error: a free push was attempted while full.

Behaviour:
- Storage:
  - entries[DEPTH] of PHYS_REG_IDX.
  - Pointers head, tail, ret_head, each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - free_count = tail - head, computed modulo 2^(ptr width).
- Reset (asynchronous):
  - entries[i] = ARCH_SZ + i.
  - head = 0, ret_head = 0, tail = DEPTH (wrap bit set, list full).
  - free_count = DEPTH, overflow_err = 0.
  - Physical regs 0..ARCH_SZ-1 are not in the list; they hold the identity mapping in the map table.
- Allocation (0-cycle latency):
  - Let k(i) = popcount(alloc_req[i-1:0]).
  - free_reg[i] = entries[(head + k(i)) mod DEPTH] when alloc_req[i] is set, else 0.
  - If alloc_stall = 0: head advances by popcount(alloc_req) at the clock edge.
  - If alloc_stall = 1: head is unchanged and free_reg is still driven, but it is invalid. Dispatch must not consume it.
- Free:
  - For each lane with retire_valid[i], write retire_t_old[i] to entries[(tail + popcount(retire_valid[i-1:0])) mod DEPTH].
  - tail advances by popcount(retire_valid).
  - Freed entries become visible to allocation the next cycle. There is no same-cycle bypass.
- Retirement shadow: ret_head advances by popcount(retire_valid) every cycle, independent of restore_en.
- Restore:
  - On restore_en: head_next = ret_head_next, i.e. ret_head plus this cycle's retire count.
  - This cycle's alloc_req is ignored and the head advance is discarded.
  - This cycle's frees still commit.
  - Result: free_count = DEPTH - (in-flight retired-but-unfreed = 0), i.e. all registers not in the architectural map are free.
- Simultaneous alloc and free:
  - count_next = count - allocs + frees.
  - A list that is empty at cycle start stalls even if frees arrive in the same cycle.
- Wrap-around: indices wrap mod DEPTH; the wrap bit distinguishes full (MSBs differ, low bits equal) from empty (pointers equal).
- Errors:
  - A free push with free_count + frees > DEPTH sets overflow_err (sticky until reset) and drops the excess pushes.
  - A simulation assertion also fires.
- Reset mid-operation: asynchronous clear to the reset state above. Any in-progress allocation is lost.

Decomposition:
- sys_defs.svh:
  - PHYS_REG_IDX typedef.
  - `N, `PHYS_REG_SZ, `ARCH_REG_SZ.
  - New macro `FL_DEPTH = (`PHYS_REG_SZ-`ARCH_REG_SZ).
  - New typedef FL_PTR (width $clog2(`FL_DEPTH)+1).
- One sub-module, lane_prefix_count: N-bit vector in, per-lane exclusive prefix counts and total out.
  - Instantiated twice, for alloc_req and retire_valid.

Test Plan (N=2, PHYS_SZ=64, ARCH_SZ=32, DEPTH=32):
1. Reset, then idle -> free_count=32, num_avail=2, alloc_stall=0, overflow_err=0. With alloc_req=2'b11, free_reg = {33,32}.
2. alloc_req=2'b10 for one cycle -> free_reg[1]=32, free_reg[0]=0. Next cycle free_count=31 and a 2'b11 request gets {34,33}.
3. Allocate 2/cycle for 16 cycles -> free_count=0, num_avail=0. Next request 2'b01 gives alloc_stall=1 and head is unchanged. In the same cycle retire_valid=2'b01 with t_old=5 -> next cycle free_count=1 and 2'b01 gets free_reg[0]=5.
4. Wrap: drain, free 40 pushes interleaved with allocations crossing index 31 -> granted order matches push order. Full/empty flags are correct across the wrap bit.
5. Allocate 6 (regs 32..37), retire 2 (t_old 3,4). Assert restore_en with alloc_req=2'b11 in the same cycle -> head = ret_head = 2, no allocation. Next cycle free_count = 32 and free_reg[0] = 34.
6. From reset (full), retire_valid=2'b11 -> overflow_err=1 next cycle and stays 1; free_count stays 32.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared sizing, types and pointer helpers for the rename free list.
package free_list_pkg;

  localparam int N       = 2;
  localparam int PHYS_SZ = 64;
  localparam int ARCH_SZ = 32;
  localparam int DEPTH   = PHYS_SZ - ARCH_SZ;
  localparam int IDX_W   = $clog2(PHYS_SZ);
  localparam int SLOT_W  = $clog2(DEPTH);
  localparam int PTR_W   = SLOT_W + 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int LANE_W  = $clog2(N + 1);

  typedef logic [IDX_W-1:0] phys_reg_idx_t;
  typedef logic [PTR_W-1:0] fl_ptr_t;

  // Storage slot addressed by a pointer; the wrap bit is dropped.
  function automatic logic [SLOT_W-1:0] ptr_slot(input fl_ptr_t p);
    return p[SLOT_W-1:0];
  endfunction

endpackage

// File: rtl/free_list_checker.sv
// Simulation-only watcher for free pushes that would overrun the list.
module free_list_checker (
  input logic clock,
  input logic reset,
  input logic overflow_push
);

  // Report each cycle in which retiring lanes find no room.
  always @(posedge clock) begin
    if (!reset) begin
      assert (!overflow_push)
        else $warning("free_list: free push while full, excess entries dropped");
    end
  end

endmodule

// File: rtl/lane_prefix_count.sv
// Per-lane exclusive prefix popcount of a lane-valid vector, plus its total.
module lane_prefix_count #(
  parameter int W  = 2,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]         vec,
  output logic [W-1:0][CW-1:0] prefix,
  output logic [CW-1:0]        total
);

  logic [CW-1:0] acc_s;

  // Running sum: lane i sees the count of set lanes below it.
  always_comb begin
    acc_s = {CW{1'b0}};
    for (int i = 0; i < W; i++) begin
      prefix[i] = acc_s;
      acc_s     = acc_s + CW'(vec[i]);
    end
    total = acc_s;
  end

endmodule

// File: rtl/free_list.sv
// Circular free list of physical register indices with a retirement-time
// head shadow so mispredict recovery restores the list in one cycle.
module free_list
  import free_list_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N-1:0]              alloc_req,
  output phys_reg_idx_t [N-1:0]     free_reg,
  output logic                      alloc_stall,
  output logic [CNT_W-1:0]          free_count,
  output logic [LANE_W-1:0]         num_avail,
  input  logic [N-1:0]              retire_valid,
  input  phys_reg_idx_t [N-1:0]     retire_t_old,
  input  logic                      restore_en,
  output logic                      overflow_err
);

  phys_reg_idx_t             entries_r [DEPTH];
  fl_ptr_t                   head_r, tail_r, ret_head_r;
  fl_ptr_t                   head_next_s, tail_next_s, ret_head_next_s;
  logic [CNT_W-1:0]          count_r, room_s;
  logic                      overflow_r, over_s;
  logic [N-1:0][LANE_W-1:0]  alloc_pre_s, free_pre_s;
  logic [LANE_W-1:0]         alloc_tot_s, free_tot_s, push_cnt_s;
  logic [N-1:0]              push_ok_s;

  lane_prefix_count #(.W(N), .CW(LANE_W)) u_alloc_cnt (
    .vec    (alloc_req),
    .prefix (alloc_pre_s),
    .total  (alloc_tot_s)
  );

  lane_prefix_count #(.W(N), .CW(LANE_W)) u_free_cnt (
    .vec    (retire_valid),
    .prefix (free_pre_s),
    .total  (free_tot_s)
  );

  // Grants read straight from storage; frees of this cycle are not bypassed.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (alloc_req[i]) begin
        free_reg[i] = entries_r[ptr_slot(head_r + PTR_W'(alloc_pre_s[i]))];
      end else begin
        free_reg[i] = {IDX_W{1'b0}};
      end
    end
  end

  // Push acceptance: lanes beyond the remaining room are dropped.
  always_comb begin
    room_s = CNT_W'(DEPTH) - count_r;
    over_s = CNT_W'(free_tot_s) > room_s;
    for (int i = 0; i < N; i++) begin
      push_ok_s[i] = retire_valid[i] && (CNT_W'(free_pre_s[i]) < room_s);
    end
    if (over_s) begin
      push_cnt_s = LANE_W'(room_s);
    end else begin
      push_cnt_s = free_tot_s;
    end
  end

  // Pointer updates; recovery snaps head to the post-retire shadow.
  always_comb begin
    alloc_stall     = CNT_W'(alloc_tot_s) > count_r;
    ret_head_next_s = ret_head_r + PTR_W'(free_tot_s);
    tail_next_s     = tail_r + PTR_W'(push_cnt_s);
    if (restore_en) begin
      head_next_s = ret_head_next_s;
    end else if (!alloc_stall) begin
      head_next_s = head_r + PTR_W'(alloc_tot_s);
    end else begin
      head_next_s = head_r;
    end
  end

  // State registers and storage writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_r     <= {PTR_W{1'b0}};
      ret_head_r <= {PTR_W{1'b0}};
      tail_r     <= PTR_W'(DEPTH);
      count_r    <= CNT_W'(DEPTH);
      overflow_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= phys_reg_idx_t'(ARCH_SZ + i);
      end
    end else begin
      head_r     <= head_next_s;
      ret_head_r <= ret_head_next_s;
      tail_r     <= tail_next_s;
      count_r    <= CNT_W'(tail_next_s - head_next_s);
      overflow_r <= overflow_r | over_s;
      for (int i = 0; i < N; i++) begin
        if (push_ok_s[i]) begin
          entries_r[ptr_slot(tail_r + PTR_W'(free_pre_s[i]))] <= retire_t_old[i];
        end
      end
    end
  end

  assign free_count   = count_r;
  assign num_avail    = (count_r > CNT_W'(N)) ? LANE_W'(N) : LANE_W'(count_r);
  assign overflow_err = overflow_r;

  free_list_checker u_chk (
    .clock         (clock),
    .reset         (reset),
    .overflow_push (over_s)
  );

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset, allocation, stall, wrap, restore, overflow.
module tb_free_list;
  import free_list_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [N-1:0]          alloc_req;
  phys_reg_idx_t [N-1:0] free_reg;
  logic                  alloc_stall;
  logic [CNT_W-1:0]      free_count;
  logic [LANE_W-1:0]     num_avail;
  logic [N-1:0]          retire_valid;
  phys_reg_idx_t [N-1:0] retire_t_old;
  logic                  restore_en;
  logic                  overflow_err;

  int checks = 0;
  int errors = 0;

  free_list dut (
    .clock        (clock),
    .reset        (reset),
    .alloc_req    (alloc_req),
    .free_reg     (free_reg),
    .alloc_stall  (alloc_stall),
    .free_count   (free_count),
    .num_avail    (num_avail),
    .retire_valid (retire_valid),
    .retire_t_old (retire_t_old),
    .restore_en   (restore_en),
    .overflow_err (overflow_err)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    alloc_req    = 2'b00;
    retire_valid = 2'b00;
    retire_t_old = '0;
    restore_en   = 1'b0;
    reset        = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL reset_count got %0d exp 32", free_count); end
    checks++; if (num_avail !== 2'd2) begin errors++; $display("FAIL reset_avail got %0d exp 2", num_avail); end
    checks++; if (alloc_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", alloc_stall); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", overflow_err); end
    alloc_req = 2'b11; #1;
    checks++; if (free_reg[0] !== 6'd32) begin errors++; $display("FAIL reset_grant0 got %0d exp 32", free_reg[0]); end
    checks++; if (free_reg[1] !== 6'd33) begin errors++; $display("FAIL reset_grant1 got %0d exp 33", free_reg[1]); end
    alloc_req = 2'b00; #1;
  endtask

  task automatic test_single_lane;
    alloc_req = 2'b10; #1;
    checks++; if (free_reg[1] !== 6'd32) begin errors++; $display("FAIL lane1_grant got %0d exp 32", free_reg[1]); end
    checks++; if (free_reg[0] !== 6'd0) begin errors++; $display("FAIL lane0_idle got %0d exp 0", free_reg[0]); end
    tick();
    alloc_req = 2'b00; #1;
    checks++; if (free_count !== 6'd31) begin errors++; $display("FAIL single_count got %0d exp 31", free_count); end
    alloc_req = 2'b11; #1;
    checks++; if (free_reg[0] !== 6'd33) begin errors++; $display("FAIL next_grant0 got %0d exp 33", free_reg[0]); end
    checks++; if (free_reg[1] !== 6'd34) begin errors++; $display("FAIL next_grant1 got %0d exp 34", free_reg[1]); end
    alloc_req = 2'b00; #1;
  endtask

  task automatic test_stall_and_free;
    do_reset();
    alloc_req = 2'b11;
    repeat (16) tick();
    alloc_req = 2'b00; #1;
    checks++; if (free_count !== 6'd0) begin errors++; $display("FAIL empty_count got %0d exp 0", free_count); end
    checks++; if (num_avail !== 2'd0) begin errors++; $display("FAIL empty_avail got %0d exp 0", num_avail); end
    alloc_req = 2'b01; retire_valid = 2'b01; retire_t_old[0] = 6'd5; #1;
    checks++; if (alloc_stall !== 1'b1) begin errors++; $display("FAIL empty_stall got %0b exp 1", alloc_stall); end
    tick();
    alloc_req = 2'b00; retire_valid = 2'b00; #1;
    checks++; if (free_count !== 6'd1) begin errors++; $display("FAIL stall_hold_count got %0d exp 1", free_count); end
    alloc_req = 2'b01; #1;
    checks++; if (alloc_stall !== 1'b0) begin errors++; $display("FAIL refill_stall got %0b exp 0", alloc_stall); end
    checks++; if (free_reg[0] !== 6'd5) begin errors++; $display("FAIL refill_grant got %0d exp 5", free_reg[0]); end
    tick();
    alloc_req = 2'b00; #1;
    checks++; if (free_count !== 6'd0) begin errors++; $display("FAIL refill_drain got %0d exp 0", free_count); end
  endtask

  task automatic test_wrap;
    do_reset();
    alloc_req = 2'b11;
    repeat (16) tick();
    alloc_req = 2'b00;
    // Pushes (2c+1, 2c+2) in cycle c are granted, in order, in cycle c+1.
    for (int c = 0; c <= 20; c++) begin
      if (c < 20) begin
        retire_valid    = 2'b11;
        retire_t_old[0] = 6'(2 * c + 1);
        retire_t_old[1] = 6'(2 * c + 2);
      end else begin
        retire_valid = 2'b00;
      end
      alloc_req = (c > 0) ? 2'b11 : 2'b00;
      #1;
      if (c > 0) begin
        checks++; if (free_reg[0] !== 6'(2 * c - 1)) begin errors++; $display("FAIL wrap_grant0 c=%0d got %0d exp %0d", c, free_reg[0], 2 * c - 1); end
        checks++; if (free_reg[1] !== 6'(2 * c)) begin errors++; $display("FAIL wrap_grant1 c=%0d got %0d exp %0d", c, free_reg[1], 2 * c); end
        checks++; if (alloc_stall !== 1'b0) begin errors++; $display("FAIL wrap_stall c=%0d got %0b exp 0", c, alloc_stall); end
      end
      tick();
    end
    alloc_req = 2'b00; retire_valid = 2'b00; #1;
    checks++; if (free_count !== 6'd0) begin errors++; $display("FAIL wrap_empty got %0d exp 0", free_count); end
    retire_valid = 2'b11;
    for (int c = 0; c < 16; c++) begin
      retire_t_old[0] = 6'(c);
      retire_t_old[1] = 6'(c + 16);
      tick();
    end
    retire_valid = 2'b00; #1;
    checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL wrap_full got %0d exp 32", free_count); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL wrap_full_ovf got %0b exp 0", overflow_err); end
    alloc_req = 2'b11; #1;
    checks++; if (free_reg[0] !== 6'd0 || free_reg[1] !== 6'd16) begin errors++; $display("FAIL wrap_full_grant got %0d,%0d exp 0,16", free_reg[0], free_reg[1]); end
    alloc_req = 2'b00; #1;
  endtask

  task automatic test_restore;
    do_reset();
    alloc_req = 2'b11;
    repeat (3) tick();
    alloc_req = 2'b00;
    retire_valid = 2'b11; retire_t_old[0] = 6'd3; retire_t_old[1] = 6'd4;
    tick();
    retire_valid = 2'b00; #1;
    checks++; if (free_count !== 6'd28) begin errors++; $display("FAIL pre_restore_count got %0d exp 28", free_count); end
    restore_en = 1'b1; alloc_req = 2'b11;
    tick();
    restore_en = 1'b0; alloc_req = 2'b00; #1;
    checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL restore_count got %0d exp 32", free_count); end
    alloc_req = 2'b11; #1;
    checks++; if (free_reg[0] !== 6'd34) begin errors++; $display("FAIL restore_grant0 got %0d exp 34", free_reg[0]); end
    checks++; if (free_reg[1] !== 6'd35) begin errors++; $display("FAIL restore_grant1 got %0d exp 35", free_reg[1]); end
    alloc_req = 2'b00; #1;
  endtask

  task automatic test_overflow;
    do_reset();
    retire_valid = 2'b11; retire_t_old[0] = 6'd7; retire_t_old[1] = 6'd8;
    tick();
    retire_valid = 2'b00; #1;
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b exp 1", overflow_err); end
    checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL ovf_count got %0d exp 32", free_count); end
    repeat (3) tick();
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", overflow_err); end
    alloc_req = 2'b11; #1;
    checks++; if (free_reg[0] !== 6'd32 || free_reg[1] !== 6'd33) begin errors++; $display("FAIL ovf_dropped got %0d,%0d exp 32,33", free_reg[0], free_reg[1]); end
    alloc_req = 2'b00; #1;
    do_reset();
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %0b exp 0", overflow_err); end
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_stall_and_free();
    test_wrap();
    test_restore();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
